// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/debug sequencer.
// The slave modport is the sequencer's view; master is the datapath/debug side.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_rs_addr_i;
    logic [4:0]       ID_rt_addr_i;
    logic             ID_uses_rt_i;
    logic             EX_mem_read_i;
    logic [4:0]       EX_rt_addr_i;
    logic             MEM_pc_src_i;
    logic             dmem_busy_i;
    logic             halt_req_i;
    logic             step_i;
    logic             cnt_clr_i;

    logic             pc_write_o;
    logic             if_id_write_o;
    logic             id_ex_write_o;
    logic             ex_mem_write_o;
    logic             mem_wb_write_o;
    logic             if_id_flush_o;
    logic             id_ex_flush_o;
    logic             ex_mem_flush_o;
    logic             halted_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [CNT_W-1:0] freeze_cnt_o;

    modport slave (
        input  ID_rs_addr_i, ID_rt_addr_i, ID_uses_rt_i,
        input  EX_mem_read_i, EX_rt_addr_i, MEM_pc_src_i,
        input  dmem_busy_i, halt_req_i, step_i, cnt_clr_i,
        output pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o, mem_wb_write_o,
        output if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
        output halted_o, stall_cnt_o, flush_cnt_o, freeze_cnt_o
    );

    modport master (
        output ID_rs_addr_i, ID_rt_addr_i, ID_uses_rt_i,
        output EX_mem_read_i, EX_rt_addr_i, MEM_pc_src_i,
        output dmem_busy_i, halt_req_i, step_i, cnt_clr_i,
        input  pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o, mem_wb_write_o,
        input  if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
        input  halted_o, stall_cnt_o, flush_cnt_o, freeze_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and debug sequencer for the 5-stage pipeline: load-use stalls, branch squashes,
// data-memory freezes, halt/single-step, plus saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe_hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        STEP   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

    logic load_use;
    logic adv;
    logic stall_inc;
    logic flush_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        logic [CNT_W-1:0] r;
        r = v;
        if (inc && (v != CNT_MAX)) begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Register zero never carries a real dependency, so a load to $0 never stalls.
    always_comb begin
        load_use = 1'b0;
        if (bus.EX_mem_read_i && (bus.EX_rt_addr_i != 5'd0)) begin
            load_use = (bus.EX_rt_addr_i == bus.ID_rs_addr_i) ||
                       (bus.ID_uses_rt_i && (bus.EX_rt_addr_i == bus.ID_rt_addr_i));
        end
    end

    assign adv       = ~bus.dmem_busy_i & ((state_q == RUN) | (state_q == STEP));
    assign stall_inc = adv & ~bus.MEM_pc_src_i & load_use;
    assign flush_inc = adv & bus.MEM_pc_src_i;

    always_comb begin
        bus.pc_write_o     = 1'b0;
        bus.if_id_write_o  = 1'b0;
        bus.id_ex_write_o  = 1'b0;
        bus.ex_mem_write_o = 1'b0;
        bus.mem_wb_write_o = 1'b0;
        bus.if_id_flush_o  = 1'b0;
        bus.id_ex_flush_o  = 1'b0;
        bus.ex_mem_flush_o = 1'b0;
        if (rst_i && adv) begin
            bus.pc_write_o     = 1'b1;
            bus.if_id_write_o  = 1'b1;
            bus.id_ex_write_o  = 1'b1;
            bus.ex_mem_write_o = 1'b1;
            bus.mem_wb_write_o = 1'b1;
            if (bus.MEM_pc_src_i) begin
                bus.if_id_flush_o  = 1'b1;
                bus.id_ex_flush_o  = 1'b1;
                bus.ex_mem_flush_o = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF_ID for one cycle; the bubble goes into ID_EX.
                bus.pc_write_o    = 1'b0;
                bus.if_id_write_o = 1'b0;
                bus.id_ex_flush_o = 1'b1;
            end
        end
    end

    assign bus.halted_o     = rst_i & (state_q == HALTED);
    assign bus.stall_cnt_o  = stall_cnt_q;
    assign bus.flush_cnt_o  = flush_cnt_q;
    assign bus.freeze_cnt_o = freeze_cnt_q;

    // A halt request only takes effect on a cycle that actually advances.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (bus.halt_req_i && !bus.dmem_busy_i) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (bus.step_i) begin
                    state_d = STEP;
                end else if (!bus.halt_req_i) begin
                    state_d = RUN;
                end
            end
            STEP: begin
                if (!bus.dmem_busy_i) begin
                    state_d = bus.halt_req_i ? HALTED : RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d  = sat_inc(stall_cnt_q, stall_inc);
        flush_cnt_d  = sat_inc(flush_cnt_q, flush_inc);
        freeze_cnt_d = sat_inc(freeze_cnt_q, bus.dmem_busy_i);
        if (bus.cnt_clr_i) begin
            stall_cnt_d  = '0;
            flush_cnt_d  = '0;
            freeze_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= RUN;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard/debug scenarios, then random traffic,
// checked against an abstract model of the pipeline-control rules.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;
    localparam int M_RUN    = 0;
    localparam int M_HALTED = 1;
    localparam int M_STEP   = 2;

    typedef struct packed {
        logic       rst;
        logic [4:0] idRs;
        logic [4:0] idRt;
        logic       usesRt;
        logic       exMemRead;
        logic [4:0] exRt;
        logic       pcSrc;
        logic       busy;
        logic       halt;
        logic       step;
        logic       clr;
    } stim_t;

    typedef struct {
        logic [4:0] wen;
        logic [2:0] fl;
        logic       halted;
        int         stallC;
        int         flushC;
        int         freezeC;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sbq[$];
    int   errCount   = 0;
    int   checkCount = 0;
    bit   stimDone   = 1'b0;

    int modeM    = M_RUN;
    int stallM   = 0;
    int flushM   = 0;
    int freezeM  = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic int satInc(input int v, input bit inc);
        return (inc && v < CNT_SAT) ? v + 1 : v;
    endfunction

    // Drives one cycle of inputs, predicts the response and advances the model.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit   dependent;
        bit   moving;
        @(negedge clk);
        rst_n             = s.rst;
        bus.ID_rs_addr_i  = s.idRs;
        bus.ID_rt_addr_i  = s.idRt;
        bus.ID_uses_rt_i  = s.usesRt;
        bus.EX_mem_read_i = s.exMemRead;
        bus.EX_rt_addr_i  = s.exRt;
        bus.MEM_pc_src_i  = s.pcSrc;
        bus.dmem_busy_i   = s.busy;
        bus.halt_req_i    = s.halt;
        bus.step_i        = s.step;
        bus.cnt_clr_i     = s.clr;

        if (!s.rst) begin
            modeM   = M_RUN;
            stallM  = 0;
            flushM  = 0;
            freezeM = 0;
            e.wen = 5'b00000; e.fl = 3'b000; e.halted = 1'b0;
            e.stallC = 0; e.flushC = 0; e.freezeC = 0;
            sbq.push_back(e);
            return;
        end

        dependent = s.exMemRead && s.exRt != 0 &&
                    (s.exRt == s.idRs || (s.usesRt && s.exRt == s.idRt));
        moving    = !s.busy && modeM != M_HALTED;

        e.wen = 5'b00000; e.fl = 3'b000;
        if (moving && s.pcSrc) begin
            e.wen = 5'b11111; e.fl = 3'b111;
        end else if (moving && dependent) begin
            e.wen = 5'b00111; e.fl = 3'b010;
        end else if (moving) begin
            e.wen = 5'b11111;
        end
        e.halted  = (modeM == M_HALTED);
        e.stallC  = stallM;
        e.flushC  = flushM;
        e.freezeC = freezeM;
        sbq.push_back(e);

        if (modeM == M_RUN && s.halt && !s.busy) modeM = M_HALTED;
        else if (modeM == M_HALTED && s.step)    modeM = M_STEP;
        else if (modeM == M_HALTED && !s.halt)   modeM = M_RUN;
        else if (modeM == M_STEP && !s.busy)     modeM = s.halt ? M_HALTED : M_RUN;

        if (s.clr) begin
            stallM = 0; flushM = 0; freezeM = 0;
        end else begin
            stallM  = satInc(stallM, moving && !s.pcSrc && dependent);
            flushM  = satInc(flushM, moving && s.pcSrc);
            freezeM = satInc(freezeM, s.busy);
        end
    endtask

    task automatic checkField(input string name, input int act, input int req);
        checkCount++;
        if (act != req) begin
            errCount++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("write_enables", int'({bus.pc_write_o, bus.if_id_write_o, bus.id_ex_write_o,
                                          bus.ex_mem_write_o, bus.mem_wb_write_o}), int'(e.wen));
        checkField("flushes", int'({bus.if_id_flush_o, bus.id_ex_flush_o, bus.ex_mem_flush_o}),
                   int'(e.fl));
        checkField("halted", int'(bus.halted_o), int'(e.halted));
        checkField("stall_cnt", int'(bus.stall_cnt_o), e.stallC);
        checkField("flush_cnt", int'(bus.flush_cnt_o), e.flushC);
        checkField("freeze_cnt", int'(bus.freeze_cnt_o), e.freezeC);
    endtask

    // Monitor: the DUT presents a response every cycle, sampled mid-low-phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        stim_t s;
        bit    haltLvl;
        int    waitCycles;

        bus.ID_rs_addr_i = '0; bus.ID_rt_addr_i = '0; bus.ID_uses_rt_i = 1'b0;
        bus.EX_mem_read_i = 1'b0; bus.EX_rt_addr_i = '0; bus.MEM_pc_src_i = 1'b0;
        bus.dmem_busy_i = 1'b0; bus.halt_req_i = 1'b0; bus.step_i = 1'b0; bus.cnt_clr_i = 1'b0;

        s = idle(); s.rst = 1'b0;
        applyStimulus(s);
        applyStimulus(s);
        applyStimulus(idle());

        $display("[TB] load-use stall on rs");
        s = idle(); s.exMemRead = 1; s.exRt = 5'd2; s.idRs = 5'd2; s.idRt = 5'd4; s.usesRt = 1;
        applyStimulus(s);
        applyStimulus(idle());

        $display("[TB] load to $0 and store rt dependency");
        s = idle(); s.exMemRead = 1; s.exRt = 5'd0; s.idRs = 5'd0; s.idRt = 5'd0; s.usesRt = 1;
        applyStimulus(s);
        s = idle(); s.exMemRead = 1; s.exRt = 5'd7; s.idRs = 5'd1; s.idRt = 5'd7; s.usesRt = 1;
        applyStimulus(s);
        s.usesRt = 0;
        applyStimulus(s);

        $display("[TB] branch over load-use");
        s = idle(); s.clr = 1;
        applyStimulus(s);
        s = idle(); s.pcSrc = 1; s.exMemRead = 1; s.exRt = 5'd3; s.idRs = 5'd3;
        applyStimulus(s);
        applyStimulus(idle());

        $display("[TB] memory freeze during branch");
        s = idle(); s.clr = 1;
        applyStimulus(s);
        s = idle(); s.pcSrc = 1; s.busy = 1;
        repeat (3) applyStimulus(s);
        s.busy = 0;
        applyStimulus(s);
        applyStimulus(idle());

        $display("[TB] halt, single step, resume");
        s = idle(); s.halt = 1;
        applyStimulus(s);
        applyStimulus(s);
        s.step = 1;
        applyStimulus(s);
        s.step = 0; s.busy = 1;
        applyStimulus(s);
        s.busy = 0;
        applyStimulus(s);
        applyStimulus(s);
        applyStimulus(idle());
        applyStimulus(idle());

        $display("[TB] stall counter saturation and clear");
        s = idle(); s.exMemRead = 1; s.exRt = 5'd5; s.idRs = 5'd5;
        repeat (CNT_SAT + 3) applyStimulus(s);
        s = idle(); s.clr = 1;
        applyStimulus(s);
        applyStimulus(idle());

        $display("[TB] reset mid-step");
        s = idle(); s.halt = 1; s.busy = 1; s.pcSrc = 1;
        applyStimulus(idle());
        s.busy = 0;
        applyStimulus(s);
        s.step = 1;
        applyStimulus(s);
        s.step = 0; s.busy = 1;
        applyStimulus(s);
        s.rst = 0;
        applyStimulus(s);
        applyStimulus(idle());
        applyStimulus(idle());

        $display("[TB] random traffic");
        haltLvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            if ($urandom_range(29) == 0) haltLvl = ~haltLvl;
            s.rst       = ($urandom_range(249) != 0);
            s.idRs      = 5'($urandom_range(3));
            s.idRt      = 5'($urandom_range(3));
            s.usesRt    = 1'($urandom_range(1));
            s.exMemRead = 1'($urandom_range(1));
            s.exRt      = 5'($urandom_range(3));
            s.pcSrc     = ($urandom_range(5) == 0);
            s.busy      = ($urandom_range(4) == 0);
            s.halt      = haltLvl;
            s.step      = ($urandom_range(7) == 0);
            s.clr       = ($urandom_range(59) == 0);
            applyStimulus(s);
        end
        stimDone = 1'b1;

        waitCycles = 0;
        while (sbq.size() > 0 && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        @(negedge clk);
        #4;
        if (sbq.size() > 0) begin
            errCount++;
            checkCount++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
